// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator with a valid/ready handshake and a sideband tag.
// The log2(XLEN) shift levels are spread over STAGES register stages; the whole pipe stalls together.
module shift_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 1,
   parameter int TAG_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [XLEN-1:0]         a,
   input  logic [$clog2(XLEN)-1:0] shamt,
   input  logic [2:0]              op,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         out_r,
   output logic [TAG_W-1:0]        out_tag
);

   localparam int SW  = $clog2(XLEN);
   localparam int PER = (SW + STAGES - 1) / STAGES;

   localparam logic [2:0] OP_SRL = 3'd0;
   localparam logic [2:0] OP_SLL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;
   localparam logic [2:0] OP_ROR = 3'd3;
   localparam logic [2:0] OP_ROL = 3'd4;

   // Index 0 is the input port side; index s+1 is the register output of stage s.
   logic             pos_v   [STAGES+1];
   logic [XLEN-1:0]  pos_d   [STAGES+1];
   logic [2:0]       pos_op  [STAGES+1];
   logic [TAG_W-1:0] pos_tag [STAGES+1];
   logic [SW-1:0]    pos_sh  [STAGES];

   logic adv;

   function automatic logic [XLEN-1:0] shift_level(input logic [XLEN-1:0] x,
                                                   input logic [2:0]      o,
                                                   input int              k);
      case (o)
         OP_SRL:  return x >> k;
         OP_SLL:  return x << k;
         OP_SRA:  return $signed(x) >>> k;
         OP_ROR:  return (x >> k) | (x << (XLEN - k));
         OP_ROL:  return (x << k) | (x >> (XLEN - k));
         default: return x;
      endcase
   endfunction

   assign adv      = !out_valid || out_ready;
   // Reset forces ready high; acceptance is still blocked because reset wins in every stage register.
   assign in_ready = adv || rst;

   assign pos_v[0]   = in_valid && adv;
   assign pos_d[0]   = a;
   assign pos_op[0]  = op;
   assign pos_tag[0] = in_tag;
   assign pos_sh[0]  = shamt;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int LO = (s * PER < SW) ? s * PER : SW;
      localparam int HI = ((s + 1) * PER < SW) ? (s + 1) * PER : SW;

      logic [XLEN-1:0]  nxt;
      logic             v_r;
      logic [XLEN-1:0]  d_r;
      logic [2:0]       op_r;
      logic [TAG_W-1:0] tag_r;

      always_comb begin
         nxt = pos_d[s];
         for (int l = 0; l < SW; l++) begin
            if (l >= LO && l < HI && pos_sh[s][l[SW-1:0]]) begin
               nxt = shift_level(nxt, pos_op[s], 1 << l);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_r   <= 1'b0;
            d_r   <= '0;
            op_r  <= '0;
            tag_r <= '0;
         end else if (adv) begin
            v_r   <= pos_v[s];
            d_r   <= nxt;
            op_r  <= pos_op[s];
            tag_r <= pos_tag[s];
         end
      end

      assign pos_v[s+1]   = v_r;
      assign pos_d[s+1]   = d_r;
      assign pos_op[s+1]  = op_r;
      assign pos_tag[s+1] = tag_r;

      // The last stage consumes the final shift levels, so no shift amount is carried past it.
      if (s < STAGES - 1) begin : g_sh
         logic [SW-1:0] sh_r;

         always_ff @(posedge clk) begin
            if (rst) begin
               sh_r <= '0;
            end else if (adv) begin
               sh_r <= pos_sh[s];
            end
         end

         assign pos_sh[s+1] = sh_r;
      end
   end

   // Reserved op codes pass the operand through the levels untouched and are zeroed here.
   assign out_valid = pos_v[STAGES];
   assign out_tag   = pos_tag[STAGES];
   assign out_r     = (pos_op[STAGES] > OP_ROL) ? '0 : pos_d[STAGES];

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: four instances (STAGES 2, 1, 3, 5) share stimulus, each with its own
// reference queue; directed cases and latency checks target the STAGES=2 instance.
module tb_shift_pipe;

   localparam int NDUT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] a = '0;
   logic [4:0]  shamt = '0;
   logic [2:0]  op = '0;
   logic [3:0]  in_tag = '0;

   logic        rdy [NDUT];
   logic        vld [NDUT];
   logic [31:0] res [NDUT];
   logic [3:0]  tg  [NDUT];

   int          n_checks = 0;
   int          n_errors = 0;
   logic [35:0] sbq [NDUT][$];
   logic        acc0 = 1'b0;

   always #5 clk = ~clk;

   shift_pipe #(.XLEN(32), .STAGES(2), .TAG_W(4)) u_s2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .a(a), .shamt(shamt),
      .op(op), .in_tag(in_tag), .out_valid(vld[0]), .out_ready(out_ready), .out_r(res[0]),
      .out_tag(tg[0]));

   shift_pipe #(.XLEN(32), .STAGES(1), .TAG_W(4)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .a(a), .shamt(shamt),
      .op(op), .in_tag(in_tag), .out_valid(vld[1]), .out_ready(out_ready), .out_r(res[1]),
      .out_tag(tg[1]));

   shift_pipe #(.XLEN(32), .STAGES(3), .TAG_W(4)) u_s3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .a(a), .shamt(shamt),
      .op(op), .in_tag(in_tag), .out_valid(vld[2]), .out_ready(out_ready), .out_r(res[2]),
      .out_tag(tg[2]));

   shift_pipe #(.XLEN(32), .STAGES(5), .TAG_W(4)) u_s5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .a(a), .shamt(shamt),
      .op(op), .in_tag(in_tag), .out_valid(vld[3]), .out_ready(out_ready), .out_r(res[3]),
      .out_tag(tg[3]));

   // Reference result straight from the operation definitions.
   function automatic logic [31:0] model(input logic [31:0] x, input int s, input logic [2:0] o);
      logic [63:0] w;
      case (o)
         3'd0: return x >> s;
         3'd1: return x << s;
         3'd2: begin w = {{32{x[31]}}, x} >> s; return w[31:0]; end
         3'd3: begin w = {x, x} >> s; return w[31:0]; end
         3'd4: begin w = {x, x} << s; return w[63:32]; end
         default: return 32'h0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Inputs are set just after a negedge; 1 time unit later the handshake seen by the next
   // posedge is settled, so the scoreboard is updated here, then we wait for the next negedge.
   task automatic tick();
      logic [35:0] e;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         if (rst) begin
            sbq[k].delete();
         end else begin
            if (vld[k] && out_ready) begin
               if (sbq[k].size() == 0) begin
                  check($sformatf("unexpected_out_dut%0d", k), 64'(vld[k]), 64'd0);
               end else begin
                  e = sbq[k].pop_front();
                  check($sformatf("result_dut%0d", k), {28'd0, tg[k], res[k]}, {28'd0, e});
               end
            end
            if (in_valid && rdy[k]) sbq[k].push_back({in_tag, model(a, int'(shamt), op)});
         end
      end
      acc0 = !rst && in_valid && rdy[0];
      @(negedge clk);
   endtask

   task automatic run_one(input string name, input logic [31:0] va, input logic [4:0] vs,
                          input logic [2:0] vo, input logic [3:0] vt, input logic [31:0] exp);
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = va;
      shamt     = vs;
      op        = vo;
      in_tag    = vt;
      tick();
      check({name, "_accept"}, 64'(acc0), 64'd1);
      in_valid = 1'b0;
      lat = 1;
      while (!vld[0] && lat < 10) begin
         tick();
         lat++;
      end
      check({name, "_latency"}, 64'(lat), 64'd2);
      check({name, "_r"}, 64'(res[0]), 64'(exp));
      check({name, "_tag"}, 64'(tg[0]), 64'(vt));
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          next_tag;
      int          seen;
      int          r;
      logic [31:0] hold_r;
      logic [3:0]  hold_t;
      logic [3:0]  got[$];

      @(negedge clk);
      rst = 1'b1;
      repeat (2) tick();
      for (int k = 0; k < NDUT; k++) check($sformatf("reset_valid_dut%0d", k), 64'(vld[k]), 64'd0);
      check("reset_out_r", 64'(res[0]), 64'd0);
      check("reset_out_tag", 64'(tg[0]), 64'd0);
      check("reset_in_ready", 64'(rdy[0]), 64'd1);
      rst = 1'b0;

      run_one("srl_31",  32'h8000_0000, 5'd31, 3'd0, 4'd5, 32'h0000_0001);
      run_one("sll_31",  32'h0000_0001, 5'd31, 3'd1, 4'd6, 32'h8000_0000);
      run_one("sra_neg", 32'h8000_0000, 5'd4,  3'd2, 4'd7, 32'hF800_0000);
      run_one("sra_pos", 32'h7FFF_FFFF, 5'd31, 3'd2, 4'd8, 32'h0000_0000);
      run_one("ror_4",   32'h0000_0001, 5'd4,  3'd3, 4'd9, 32'h1000_0000);
      run_one("rol_1",   32'h8000_0001, 5'd1,  3'd4, 4'd10, 32'h0000_0003);
      run_one("rsv_7",   32'hDEAD_BEEF, 5'd3,  3'd7, 4'd11, 32'h0000_0000);
      for (int o = 0; o < 5; o++) begin
         run_one($sformatf("zero_sh_op%0d", o), 32'hA5A5_0F0F, 5'd0, 3'(o), 4'(o), 32'hA5A5_0F0F);
      end
      run_one("rsv_5_zero", 32'hA5A5_0F0F, 5'd0, 3'd5, 4'd12, 32'h0000_0000);

      // Backpressure: three tagged ops offered while the consumer stalls.
      out_ready = 1'b0;
      next_tag  = 1;
      a         = 32'h1234_5678;
      shamt     = 5'd8;
      op        = 3'd3;
      hold_r    = '0;
      hold_t    = '0;
      for (int c = 0; c < 4; c++) begin
         in_valid = (next_tag <= 3);
         in_tag   = 4'(next_tag);
         tick();
         if (acc0) next_tag++;
         if (c == 1) begin
            hold_r = res[0];
            hold_t = tg[0];
         end
      end
      check("bp_in_ready_low", 64'(rdy[0]), 64'd0);
      check("bp_out_valid", 64'(vld[0]), 64'd1);
      check("bp_accepted", 64'(next_tag), 64'd3);
      check("bp_hold_r", 64'(res[0]), 64'(hold_r));
      check("bp_hold_tag", 64'(tg[0]), 64'(hold_t));
      check("bp_head_tag", 64'(tg[0]), 64'd1);
      check("bp_head_r", 64'(res[0]), 64'h7812_3456);
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_valid = (next_tag <= 3);
         in_tag   = 4'(next_tag);
         if (vld[0]) got.push_back(tg[0]);
         tick();
         if (acc0) next_tag++;
      end
      in_valid = 1'b0;
      check("bp_count", 64'(got.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp_order_%0d", i), 64'((i < got.size()) ? got[i] : 4'hF), 64'(i + 1));
      end

      // Reset with two ops in flight and the output stalled.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = 32'hCAFE_F00D;
      shamt     = 5'd3;
      op        = 3'd1;
      in_tag    = 4'd9;
      tick();
      in_tag = 4'd10;
      tick();
      rst       = 1'b1;
      out_ready = 1'b0;
      in_tag    = 4'd11;
      #1;
      check("rst_in_ready", 64'(rdy[0]), 64'd1);
      tick();
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("rst_out_valid", 64'(vld[0]), 64'd0);
      check("rst_out_r", 64'(res[0]), 64'd0);
      check("rst_out_tag", 64'(tg[0]), 64'd0);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (vld[0]) seen++;
         tick();
      end
      check("rst_flushed", 64'(seen), 64'd0);
      run_one("post_rst", 32'h0000_00F0, 5'd4, 3'd0, 4'd13, 32'h0000_000F);

      // Random traffic with random backpressure, all instances checked against the model.
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a         = $urandom;
         r         = $urandom_range(0, 7);
         shamt     = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(0, 31));
         op        = 3'($urandom_range(0, 7));
         in_tag    = 4'($urandom_range(0, 15));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (12) tick();
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("drain_dut%0d", k), 64'(sbq[k].size()), 64'd0);
         check($sformatf("idle_dut%0d", k), 64'(vld[k]), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
